// File: rtl/matrix_add_sequencer.sv
// matrix_add_sequencer: walks every (row, col) of a ROWS x COLS matrix in row-major order,
// presenting one element per accepted cycle to a shared matrix-add datapath.
module matrix_add_sequencer #(
    parameter int ROWS  = 10,
    parameter int COLS  = 3,
    parameter int ROW_W = 4,
    parameter int COL_W = 2,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dp_ready,
    output logic             busy,
    output logic             stmt_en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_n;
    logic [ROW_W-1:0] row_n;
    logic [COL_W-1:0] col_n;
    logic [IDX_W-1:0] idx_n;
    logic wrap, adv, stay, last_n;
    // indices only survive while the walk stays in RUN; every other path clears them
    always_comb begin
        wrap    = col == COL_W'(COLS - 1);
        adv     = state == RUN && dp_ready && !abort && !last;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (abort ? IDLE : (dp_ready && last) ? DONE : RUN) : IDLE;
        stay    = state == RUN && state_n == RUN;
        col_n   = !stay ? '0 : adv ? (wrap ? '0 : col + COL_W'(1)) : col;
        row_n   = !stay ? '0 : (adv && wrap) ? row + ROW_W'(1) : row;
        idx_n   = !stay ? '0 : adv ? idx + IDX_W'(1) : idx;
        last_n  = state_n == RUN && row_n == ROW_W'(ROWS - 1) && col_n == COL_W'(COLS - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            stmt_en <= 1'b0;
            done    <= 1'b0;
            last    <= 1'b0;
            row     <= '0;
            col     <= '0;
            idx     <= '0;
        end else begin
            state   <= state_n;
            busy    <= state_n != IDLE;
            stmt_en <= state_n == RUN;
            done    <= state_n == DONE;
            last    <= last_n;
            row     <= row_n;
            col     <= col_n;
            idx     <= idx_n;
        end
    end
endmodule

// File: tb/tb_matrix_add_sequencer.sv
// tb_matrix_add_sequencer: randomized and directed checks of the element walk against
// a reference that tracks how many elements have been accepted in the current pass.
module tb_matrix_add_sequencer;
    localparam int ROWS = 10, COLS = 3, N = ROWS * COLS;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dp_ready = 1'b1;
    logic busy, stmt_en, last, done;
    logic [3:0] row;
    logic [1:0] col;
    logic [4:0] idx;
    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic busy1, stmt_en1, last1, done1;
    logic [0:0] row1, col1, idx1;
    int total = 0, bad = 0;
    int ph = 0, k = 0;

    matrix_add_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dp_ready(dp_ready),
        .busy(busy), .stmt_en(stmt_en), .row(row), .col(col), .idx(idx),
        .last(last), .done(done)
    );
    matrix_add_sequencer #(.ROWS(1), .COLS(1), .ROW_W(1), .COL_W(1), .IDX_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dp_ready(dp_ready),
        .busy(busy1), .stmt_en(stmt_en1), .row(row1), .col(col1), .idx(idx1),
        .last(last1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ph: 0 idle, 1 presenting element k, 2 completion cycle
    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(ph != 0));
        chk({tag, ".stmt_en"}, 32'(stmt_en), 32'(ph == 1));
        chk({tag, ".done"}, 32'(done), 32'(ph == 2));
        chk({tag, ".last"}, 32'(last), 32'(ph == 1 && k == N - 1));
        if (ph != 2) begin
            chk({tag, ".row"}, 32'(row), ph == 1 ? k / COLS : 0);
            chk({tag, ".col"}, 32'(col), ph == 1 ? k % COLS : 0);
            chk({tag, ".idx"}, 32'(idx), ph == 1 ? k : 0);
        end
    endtask

    task automatic cyc(input string tag, input bit s, input bit a, input bit r);
        start = s;
        abort = a;
        dp_ready = r;
        @(posedge clk);
        if (ph == 0) begin
            if (s) begin ph = 1; k = 0; end
        end else if (ph == 1) begin
            if (a) ph = 0;
            else if (r) begin
                if (k == N - 1) ph = 2;
                else k++;
            end
        end else ph = 0;
        #1;
        check_all(tag);
    endtask

    initial begin
        int g, n, stalls;
        start = 1'b1;
        #2;
        check_all("reset_async");
        @(posedge clk); #1;
        check_all("reset_hold_start");
        rst_n = 1'b1;
        start = 1'b0;
        cyc("idle0", 0, 0, 1);
        cyc("idle1", 0, 1, 1);
        // full pass with dp_ready held high
        cyc("full", 1, 0, 1);
        n = 1;
        for (g = 0; g < 60 && ph != 0; g++) begin
            cyc("full", 0, 0, 1);
            n++;
            if (done) chk("full_done_cycle", 32'(n), 32'(N + 1));
        end
        chk("full_bound", 32'(g < 60), 32'd1);
        // backpressure at (3,1): four stalled cycles
        cyc("bp", 1, 0, 1);
        n = 1;
        stalls = 0;
        for (g = 0; g < 80 && ph != 0; g++) begin
            bit r;
            r = !(k == 10 && stalls < 4);
            if (!r) stalls++;
            cyc("bp", 0, 0, r);
            n++;
            if (!r) chk("bp_hold_idx", 32'(idx), 32'd10);
            if (done) chk("bp_done_cycle", 32'(n), 32'd35);
        end
        chk("bp_bound", 32'(g < 80), 32'd1);
        // abort at idx 17, restart, then abort on the last element
        cyc("ab", 1, 0, 1);
        for (g = 0; g < 200 && k < 17; g++) cyc("ab_run", 0, 0, 1'($urandom_range(1)));
        chk("ab_bound", 32'(k), 32'd17);
        cyc("ab_hit", 0, 1, 1);
        chk("ab_idle", 32'(busy), 32'd0);
        cyc("ab_restart", 1, 0, 1);
        chk("ab_restart_idx", 32'(idx), 32'd0);
        for (g = 0; g < 200 && k < N - 1; g++) cyc("ab_run2", 0, 0, 1'($urandom_range(1)));
        cyc("ab_last", 0, 1, 1);
        cyc("ab_last_nodone", 0, 0, 1);
        chk("ab_last_done", 32'(done), 32'd0);
        // start held high for a whole pass and beyond
        cyc("hold", 1, 0, 1);
        for (g = 0; g < 60 && ph != 2; g++) cyc("hold_run", 1, 0, 1);
        cyc("hold_idle", 1, 0, 1);
        chk("hold_gap", 32'(stmt_en), 32'd0);
        cyc("hold_restart", 1, 0, 1);
        chk("hold_restart_en", 32'(stmt_en), 32'd1);
        cyc("hold_abort", 0, 1, 1);
        // randomized passes with random backpressure and rare aborts
        for (int p = 0; p < 8; p++) begin
            cyc("rnd_start", 1, 0, 1'($urandom_range(1)));
            for (g = 0; g < 300 && ph != 0; g++)
                cyc("rnd", 0, $urandom_range(63) == 0, $urandom_range(3) != 0);
            chk("rnd_bound", 32'(g < 300), 32'd1);
            cyc("rnd_gap", 0, 0, 1);
        end
        // asynchronous reset between edges at idx 12
        cyc("ar", 1, 0, 1);
        for (g = 0; g < 40 && k < 12; g++) cyc("ar_run", 0, 0, 1);
        #3;
        rst_n = 1'b0;
        ph = 0;
        #1;
        check_all("ar_async");
        @(posedge clk); #1;
        check_all("ar_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("ar_after", 0, 0, 1);
        // degenerate 1x1 instance
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("deg_en", 32'(stmt_en1), 32'd1);
        chk("deg_last", 32'(last1), 32'd1);
        chk("deg_idx", 32'(idx1), 32'd0);
        chk("deg_done0", 32'(done1), 32'd0);
        @(posedge clk); #1;
        chk("deg_done", 32'(done1), 32'd1);
        chk("deg_en2", 32'(stmt_en1), 32'd0);
        chk("deg_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        chk("deg_idle", 32'(busy1), 32'd0);
        chk("deg_done2", 32'(done1), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_add_sequencer.md
# matrix_add_sequencer

Element-wise sequencer for the compiler-generated matrix-add datapath (y = x + a, x and y ROWS×COLS matrices of 64-bit words, a scalar). It replaces the single-shot statement strobe with a walk over every element. The walk runs in row-major order, one (row, col) per accepted cycle, so one shared 64-bit adder serves the whole matrix. It sits between the function-level start/done handshake and the datapath's statement-enable and index inputs.

## Interface
- ROWS, 10, matrix row count (≥1)
- COLS, 3, matrix column count (≥1)
- ROW_W, 4, row index width; 2^ROW_W ≥ ROWS
- COL_W, 2, column index width; 2^COL_W ≥ COLS
- IDX_W, 5, linear index width; 2^IDX_W ≥ ROWS*COLS
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  terminate a pass; sampled only in RUN
- dp_ready  in  1  datapath accepts the element currently presented
- busy  out  1  high in RUN and DONE
- stmt_en  out  1  element valid to the datapath
- row  out  ROW_W  current row index
- col  out  COL_W  current column index
- idx  out  IDX_W  linear index, row*COLS+col
- last  out  1  presented element is (ROWS-1, COLS-1)
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. 2-bit registered state. All outputs are registered.
- Reset (rst_n low, any time, including mid-pass): state=IDLE. busy, stmt_en, last and done are 0. row, col and idx are 0. The adder receives no further stmt_en.
- IDLE:
  - start=1 → RUN, with row=col=idx=0, stmt_en=1, busy=1, and last=1 only if ROWS*COLS=1.
  - abort is ignored.
- RUN: stmt_en=1. The presented element is accepted in a cycle where dp_ready=1.
  - Accept, not last: col+1. If col=COLS-1, col wraps to 0 and row+1. idx+1. last is recomputed for the new element.
  - Accept, last → DONE. stmt_en=0, done=1.
  - dp_ready=0: row, col, idx and last hold. stmt_en stays 1.
  - abort=1 → IDLE. stmt_en=0, busy=0, indices cleared, no done pulse. abort wins over a simultaneous accept, including on the last element.
  - start is ignored.
- DONE: the state lasts exactly one cycle, with done=1 and busy=1. The next state is unconditionally IDLE, with done=0 and busy=0. start in DONE is ignored; start must be re-asserted in IDLE.
- Arithmetic: counters are unsigned, wrap only at COLS-1 and ROWS-1, and never pass ROWS*COLS-1. idx always equals row*COLS+col.

## Timing
- start seen high in IDLE at edge t → first element presented in cycle t+1.
- With dp_ready held 1: element k is presented in cycle t+1+k. last is presented in cycle t+ROWS*COLS. done is high in cycle t+ROWS*COLS+1. IDLE is re-entered at t+ROWS*COLS+2.
  - Default 10×3: elements in cycles t+1..t+30, done in cycle t+31.
- Each dp_ready=0 cycle in RUN adds exactly one cycle to the latency.
- Fastest restart: start high in the first IDLE cycle after done, giving a 1-cycle gap between done and the next stmt_en.
- abort high at edge u in RUN → IDLE in cycle u+1.

## Test plan
- Reset: hold rst_n=0 with start=1 → all outputs 0, state IDLE. Release → still idle until a start edge.
- Full pass, default 10×3, dp_ready=1: start pulse at cycle 0 →
  - stmt_en high for cycles 1..30.
  - (row,col) goes (0,0),(0,1),(0,2),(1,0)…(9,2), with idx 0..29.
  - last only in cycle 30.
  - done only in cycle 31; busy high in cycles 1..31.
- Backpressure: dp_ready=0 at (3,1) for 4 cycles → indices hold at row=3, col=1, idx=10 with stmt_en=1. The done pulse shifts to cycle 35. There is no skipped or duplicated index.
- Abort:
  - abort at idx=17 → next cycle IDLE, all outputs 0, no done.
  - A following start restarts at (0,0).
  - abort on the cycle where last is accepted → no done.
- Ignored start: start held high throughout a pass → no restart during RUN or DONE. A second pass begins in the cycle after the IDLE cycle.
- Async reset mid-pass: rst_n low between edges at idx=12 → outputs 0 immediately, without waiting for the clock edge. No done pulse follows.
- Degenerate ROWS=1, COLS=1: start → a single element with last=1 in cycle 1, done in cycle 2.
